// File: rtl/prog_memory_if.sv
// rtl/prog_memory_if.sv - load-stream and CPU-port bundle for prog_memory
interface prog_memory_if #(
   parameter int DATA_W  = 16,
   parameter int WORD_AW = 7
);
   localparam int BE_W    = DATA_W / 8;
   localparam int BYTE_AW = WORD_AW + $clog2(BE_W);

   logic                load_start;
   logic [WORD_AW:0]    load_len;
   logic                load_valid;
   logic [DATA_W-1:0]   load_data;
   logic                load_ready;
   logic                load_overflow;
   logic                cpu_run;
   logic [BYTE_AW-1:0]  mem_addr;
   logic                mem_we;
   logic [BE_W-1:0]     mem_be;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;

   modport master (
      output load_start, load_len, load_valid, load_data,
      output mem_addr, mem_we, mem_be, mem_wdata,
      input  load_ready, load_overflow, cpu_run, mem_rdata
   );

   modport slave (
      input  load_start, load_len, load_valid, load_data,
      input  mem_addr, mem_we, mem_be, mem_wdata,
      output load_ready, load_overflow, cpu_run, mem_rdata
   );
endinterface

// File: rtl/prog_memory.sv
// rtl/prog_memory.sv - unified program memory with clear+load engine and byte-enabled CPU port
module prog_memory #(
   parameter int DATA_W  = 16,
   parameter int WORD_AW = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   prog_memory_if.slave  bus
);
   localparam int BE_W    = DATA_W / 8;
   localparam int OFF_W   = $clog2(BE_W);
   localparam int BYTE_AW = WORD_AW + OFF_W;
   localparam int DEPTH   = 2 ** WORD_AW;
   localparam logic [WORD_AW:0] DEPTH_L = {1'b1, {WORD_AW{1'b0}}};

   typedef enum logic [1:0] {IDLE, CLEAR, LOAD, RUN} state_t;

   state_t              state_q, state_d;
   logic [WORD_AW:0]    len_q, len_d;
   logic [WORD_AW:0]    cnt_q, cnt_d;
   logic [WORD_AW:0]    cnt_inc;
   logic                ovf_q, ovf_d;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                wr_en;
   logic [WORD_AW-1:0]  wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [BE_W-1:0]     wr_be;
   logic [WORD_AW-1:0]  cpu_word;
   logic                xfer;

   // Byte-offset bits select nothing within a word access; keep them visibly consumed.
   generate
      if (OFF_W > 0) begin : g_off
         logic unused_addr_bits;
         assign unused_addr_bits = ^bus.mem_addr[OFF_W-1:0];
      end
   endgenerate

   assign cpu_word          = bus.mem_addr[BYTE_AW-1 -: WORD_AW];
   // Gated by rst_n so the handshake and CPU release drop in the reset cycle itself.
   assign bus.load_ready    = rst_n && (state_q == LOAD);
   assign bus.cpu_run       = rst_n && (state_q == RUN);
   assign bus.load_overflow = ovf_q;
   assign bus.mem_rdata     = rdata_q;
   assign xfer              = bus.load_valid && bus.load_ready;
   assign cnt_inc           = cnt_q + 1'b1;

   // Sequencer next state plus the single write-port mux shared by clear, load and CPU.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      wr_addr = cnt_q[WORD_AW-1:0];
      wr_data = '0;
      wr_be   = '1;
      case (state_q)
         IDLE, RUN: begin
            if (state_q == RUN && bus.mem_we) begin
               wr_en   = 1'b1;
               wr_addr = cpu_word;
               wr_data = bus.mem_wdata;
               wr_be   = bus.mem_be;
            end
            if (bus.load_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
               ovf_d   = (bus.load_len > DEPTH_L);
               len_d   = (bus.load_len > DEPTH_L) ? DEPTH_L : bus.load_len;
            end
         end
         CLEAR: begin
            wr_en = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_q[WORD_AW-1:0] == {WORD_AW{1'b1}}) begin
               cnt_d   = '0;
               state_d = (len_q == '0) ? RUN : LOAD;
            end
         end
         LOAD: begin
            if (xfer) begin
               wr_en   = 1'b1;
               wr_data = bus.load_data;
               cnt_d   = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d = RUN;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Array write, byte-granular; contents survive reset by design.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         for (int i = 0; i < BE_W; i++) begin
            if (wr_be[i]) begin
               mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
         end
      end
   end

   // Registered read; pre-write data on same-word collisions, zero outside RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (state_q == RUN) begin
         rdata_q <= mem[cpu_word];
      end else begin
         rdata_q <= '0;
      end
   end
endmodule

// File: tb/tb_prog_memory.sv
// tb/tb_prog_memory.sv - scoreboard bench for prog_memory
module tb_prog_memory;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   prog_memory_if #(.DATA_W(16), .WORD_AW(7)) ifa ();
   prog_memory_if #(.DATA_W(32), .WORD_AW(4)) ifb ();

   prog_memory #(.DATA_W(16), .WORD_AW(7)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   prog_memory #(.DATA_W(32), .WORD_AW(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   logic [15:0] qa[$];
   string       qna[$];
   logic [31:0] qb[$];
   string       qnb[$];
   logic        rda_issue, rda_vld;
   logic        rdb_issue, rdb_vld;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      rda_vld <= rda_issue;
      rdb_vld <= rdb_issue;
   end

   always @(negedge clk) begin : monitor
      logic [31:0] e;
      string       n;
      if (rda_vld) begin
         if (qa.size() == 0) chk("sb_a_empty", 32'd1, 32'd0);
         else begin
            e = {16'h0, qa.pop_front()};
            n = qna.pop_front();
            chk(n, {16'h0, ifa.mem_rdata}, e);
         end
      end
      if (rdb_vld) begin
         if (qb.size() == 0) chk("sb_b_empty", 32'd1, 32'd0);
         else begin
            e = qb.pop_front();
            n = qnb.pop_front();
            chk(n, ifb.mem_rdata, e);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_a(input int len);
      ifa.load_start = 1'b1;
      ifa.load_len   = 8'(len);
      step();
      ifa.load_start = 1'b0;
   endtask

   task automatic wait_a_ready(output int c);
      c = 0;
      while (!ifa.load_ready && c < 400) begin step(); c++; end
   endtask

   task automatic wait_a_run(output int c);
      c = 0;
      while (!ifa.cpu_run && c < 400) begin step(); c++; end
   endtask

   task automatic send_a(input logic [15:0] d, input int gap);
      ifa.load_valid = 1'b0;
      repeat (gap) step();
      ifa.load_valid = 1'b1;
      ifa.load_data  = d;
      step();
      ifa.load_valid = 1'b0;
   endtask

   task automatic rd_a(input logic [7:0] addr, input logic [15:0] exp, input string nm);
      ifa.mem_addr = addr;
      rda_issue    = 1'b1;
      qa.push_back(exp);
      qna.push_back(nm);
      step();
      rda_issue    = 1'b0;
   endtask

   task automatic wr_a(input logic [7:0] addr, input logic [1:0] be, input logic [15:0] d);
      ifa.mem_addr  = addr;
      ifa.mem_we    = 1'b1;
      ifa.mem_be    = be;
      ifa.mem_wdata = d;
      step();
      ifa.mem_we    = 1'b0;
   endtask

   task automatic rd_b(input logic [5:0] addr, input logic [31:0] exp, input string nm);
      ifb.mem_addr = addr;
      rdb_issue    = 1'b1;
      qb.push_back(exp);
      qnb.push_back(nm);
      step();
      rdb_issue    = 1'b0;
   endtask

   task automatic wr_b(input logic [5:0] addr, input logic [3:0] be, input logic [31:0] d);
      ifb.mem_addr  = addr;
      ifb.mem_we    = 1'b1;
      ifb.mem_be    = be;
      ifb.mem_wdata = d;
      step();
      ifb.mem_we    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int c;
      rst_n = 1'b0;
      rda_issue = 1'b0; rdb_issue = 1'b0;
      ifa.load_start = 1'b0; ifa.load_len = '0; ifa.load_valid = 1'b0; ifa.load_data = '0;
      ifa.mem_addr = '0; ifa.mem_we = 1'b0; ifa.mem_be = '0; ifa.mem_wdata = '0;
      ifb.load_start = 1'b0; ifb.load_len = '0; ifb.load_valid = 1'b0; ifb.load_data = '0;
      ifb.mem_addr = '0; ifb.mem_we = 1'b0; ifb.mem_be = '0; ifb.mem_wdata = '0;
      step(2);
      chk("rst_cpu_run", ifa.cpu_run, 0);
      chk("rst_load_ready", ifa.load_ready, 0);
      chk("rst_rdata", ifa.mem_rdata, 0);
      chk("rst_overflow", ifa.load_overflow, 0);
      rst_n = 1'b1;
      step();

      start_a(3);
      wait_a_ready(c);
      chk("clear_cycles", c, 128);
      send_a(16'hF10A, 0);
      send_a(16'hF202, 0);
      chk("run_before_last", ifa.cpu_run, 0);
      send_a(16'h7312, 0);
      chk("run_after_load", ifa.cpu_run, 1);
      chk("ready_after_load", ifa.load_ready, 0);
      rd_a(8'h00, 16'hF10A, "rd_w0");
      rd_a(8'h02, 16'hF202, "rd_w1");
      rd_a(8'h04, 16'h7312, "rd_w2");
      rd_a(8'h06, 16'h0000, "rd_w3_cleared");
      rd_a(8'h05, 16'h7312, "rd_odd_addr");

      wr_a(8'h02, 2'b10, 16'hAB55);
      rd_a(8'h02, 16'hAB02, "be_high_byte");
      wr_a(8'h02, 2'b00, 16'hFFFF);
      rd_a(8'h02, 16'hAB02, "be_none");
      ifa.mem_addr = 8'h02; ifa.mem_we = 1'b1; ifa.mem_be = 2'b11; ifa.mem_wdata = 16'h1234;
      rda_issue = 1'b1; qa.push_back(16'hAB02); qna.push_back("rdw_old_data");
      step();
      ifa.mem_we = 1'b0; rda_issue = 1'b0;
      rd_a(8'h02, 16'h1234, "rdw_new_data");

      start_a(2);
      chk("reload_run_drop", ifa.cpu_run, 0);
      wait_a_ready(c);
      chk("reload_clear_cycles", c, 128);
      wr_a(8'h10, 2'b11, 16'hDEAD);
      chk("rdata_outside_run", ifa.mem_rdata, 0);
      send_a(16'h1111, 0);
      chk("gap_run_early", ifa.cpu_run, 0);
      send_a(16'h2222, 2);
      chk("gap_run", ifa.cpu_run, 1);
      rd_a(8'h00, 16'h1111, "reload_w0");
      rd_a(8'h02, 16'h2222, "reload_w1");
      rd_a(8'h04, 16'h0000, "reload_w2_cleared");
      rd_a(8'h10, 16'h0000, "load_cpu_write_ignored");

      start_a(0);
      wait_a_run(c);
      chk("zero_len_cycles", c, 128);
      rd_a(8'h00, 16'h0000, "zero_w0");
      rd_a(8'h02, 16'h0000, "zero_w1");
      rd_a(8'hFE, 16'h0000, "zero_w127");

      start_a(200);
      chk("ovf_set", ifa.load_overflow, 1);
      wait_a_ready(c);
      chk("ovf_clear_cycles", c, 128);
      for (int i = 0; i < 128; i++) begin
         send_a(16'h1000 + 16'(i), 0);
         if (i == 126) chk("ovf_run_early", ifa.cpu_run, 0);
      end
      chk("ovf_run", ifa.cpu_run, 1);
      chk("ovf_sticky", ifa.load_overflow, 1);
      rd_a(8'h00, 16'h1000, "ovf_w0");
      rd_a(8'h7E, 16'h103F, "ovf_w63");
      rd_a(8'hFE, 16'h107F, "ovf_w127");

      start_a(4);
      chk("ovf_cleared", ifa.load_overflow, 0);
      wait_a_ready(c);
      send_a(16'h5555, 0);
      start_a(3);
      chk("start_ignored_ready", ifa.load_ready, 1);
      send_a(16'h6666, 0);
      send_a(16'h7777, 0);
      chk("len4_not_done", ifa.cpu_run, 0);
      rst_n = 1'b0;
      step();
      chk("midload_rst_ready", ifa.load_ready, 0);
      chk("midload_rst_run", ifa.cpu_run, 0);
      chk("midload_rst_rdata", ifa.mem_rdata, 0);
      rst_n = 1'b1;
      step(3);
      chk("idle_ready", ifa.load_ready, 0);
      chk("idle_run", ifa.cpu_run, 0);

      ifb.load_start = 1'b1; ifb.load_len = 5'd2;
      step();
      ifb.load_start = 1'b0;
      c = 0;
      while (!ifb.load_ready && c < 100) begin step(); c++; end
      chk("b_clear_cycles", c, 16);
      ifb.load_valid = 1'b1; ifb.load_data = 32'h11223344;
      step();
      ifb.load_data = 32'h55667788;
      step();
      ifb.load_valid = 1'b0;
      chk("b_run", ifb.cpu_run, 1);
      wr_b(6'h00, 4'b0100, 32'hAABBCCDD);
      rd_b(6'h00, 32'h11BB3344, "b_be_byte2");
      rd_b(6'h07, 32'h55667788, "b_w1");
      rd_b(6'h0B, 32'h00000000, "b_w2_cleared");
      wr_b(6'h0B, 4'b1111, 32'hCAFEF00D);
      rd_b(6'h08, 32'hCAFEF00D, "b_addr0B_word2");

      step(3);
      if (qa.size() != 0 || qb.size() != 0) chk("sb_drained", 32'(qa.size() + qb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
